// File: rtl/regfile_arbiter.sv
// Arbitrates two request ports onto one register file through an IDLE/ISSUE/READ/RESP FSM.
// Accept edge E0 leads to response valid after E2; the response holds until the owner takes it.
module regfile_arbiter #(
  parameter int RR_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [31:0] a_instr,
  input  logic        a_we,
  input  logic [31:0] a_wdata,
  output logic        a_resp_valid,
  input  logic        a_resp_ready,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [31:0] b_instr,
  input  logic        b_we,
  input  logic [31:0] b_wdata,
  output logic        b_resp_valid,
  input  logic        b_resp_ready,
  output logic [31:0] resp_rd1,
  output logic [31:0] resp_rd2,
  output logic [31:0] rf_instr,
  output logic        rf_regwrite,
  output logic [31:0] rf_writedata,
  input  logic [31:0] rf_rd1,
  input  logic [31:0] rf_rd2,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, READ, RESP} state_t;

  state_t      state;
  logic        owner;   // 0 = A, 1 = B
  logic        last_b;  // last grant went to B
  logic        grant_a;
  logic        grant_b;
  logic [31:0] sel_instr;
  logic [31:0] sel_wdata;
  logic        sel_we;
  logic        owner_taken;

  always_comb begin
    grant_a     = a_valid & (~b_valid | (RR_EN == 0) | last_b);
    grant_b     = b_valid & ~grant_a;
    a_ready     = (state == IDLE) & ~rst & grant_a;
    b_ready     = (state == IDLE) & ~rst & grant_b;
    sel_instr   = grant_b ? b_instr : a_instr;
    sel_wdata   = grant_b ? b_wdata : a_wdata;
    sel_we      = grant_b ? b_we    : a_we;
    owner_taken = owner ? b_resp_ready : a_resp_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= 1'b0;
      last_b       <= 1'b1;
      rf_instr     <= '0;
      rf_writedata <= '0;
      rf_regwrite  <= 1'b0;
      resp_rd1     <= '0;
      resp_rd2     <= '0;
      a_resp_valid <= 1'b0;
      b_resp_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_a | grant_b) begin
            rf_instr     <= sel_instr;
            rf_writedata <= sel_wdata;
            // x0 is hardwired, so a write to rd=0 never reaches the file
            rf_regwrite  <= sel_we & (sel_instr[11:7] != 5'd0);
            owner        <= grant_b;
            last_b       <= grant_b;
            busy         <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          rf_regwrite <= 1'b0;
          state       <= READ;
        end
        READ: begin
          // File output here was read at the ISSUE->READ edge, before the write landed
          resp_rd1     <= rf_rd1;
          resp_rd2     <= rf_rd2;
          a_resp_valid <= ~owner;
          b_resp_valid <= owner;
          state        <= RESP;
        end
        RESP: begin
          if (owner_taken) begin
            a_resp_valid <= 1'b0;
            b_resp_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Randomized bench for regfile_arbiter with a behavioural register-file scoreboard.
module tb_regfile_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b1;
  logic        a_valid = 0, b_valid = 0, a_we = 0, b_we = 0;
  logic        a_resp_ready = 0, b_resp_ready = 0;
  logic [31:0] a_instr = 0, b_instr = 0, a_wdata = 0, b_wdata = 0;
  logic        a_ready, b_ready, a_resp_valid, b_resp_valid, rf_regwrite, busy;
  logic [31:0] resp_rd1, resp_rd2, rf_instr, rf_writedata, rf_rd1, rf_rd2;

  logic        fp_a_ready, fp_b_ready, fp_a_resp_valid, fp_b_resp_valid, fp_rf_regwrite, fp_busy;
  logic [31:0] fp_resp_rd1, fp_resp_rd2, fp_rf_instr, fp_rf_writedata;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int exp_writes = 0;
  logic [31:0] env_regs [32];
  logic [31:0] ref_regs [32];

  always #5 clk = ~clk;

  regfile_arbiter #(.RR_EN(1)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_instr(a_instr), .a_we(a_we), .a_wdata(a_wdata),
    .a_resp_valid(a_resp_valid), .a_resp_ready(a_resp_ready),
    .b_valid(b_valid), .b_ready(b_ready), .b_instr(b_instr), .b_we(b_we), .b_wdata(b_wdata),
    .b_resp_valid(b_resp_valid), .b_resp_ready(b_resp_ready),
    .resp_rd1(resp_rd1), .resp_rd2(resp_rd2),
    .rf_instr(rf_instr), .rf_regwrite(rf_regwrite), .rf_writedata(rf_writedata),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .busy(busy)
  );

  regfile_arbiter #(.RR_EN(0)) dut_fp (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(fp_a_ready), .a_instr(a_instr), .a_we(a_we), .a_wdata(a_wdata),
    .a_resp_valid(fp_a_resp_valid), .a_resp_ready(a_resp_ready),
    .b_valid(b_valid), .b_ready(fp_b_ready), .b_instr(b_instr), .b_we(b_we), .b_wdata(b_wdata),
    .b_resp_valid(fp_b_resp_valid), .b_resp_ready(b_resp_ready),
    .resp_rd1(fp_resp_rd1), .resp_rd2(fp_resp_rd2),
    .rf_instr(fp_rf_instr), .rf_regwrite(fp_rf_regwrite), .rf_writedata(fp_rf_writedata),
    .rf_rd1(32'h0), .rf_rd2(32'h0), .busy(fp_busy)
  );

  // Register file: registered reads, read-before-write, x0 reads zero
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 32; i++) env_regs[i] <= 32'h0;
    end else begin
      rf_rd1 <= env_regs[rf_instr[19:15]];
      rf_rd2 <= env_regs[rf_instr[24:20]];
      if (rf_regwrite && rf_instr[11:7] != 5'd0) env_regs[rf_instr[11:7]] <= rf_writedata;
    end
  end

  always @(negedge clk) if (rf_regwrite) pulses++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    return {7'h0, rs2, rs1, 3'h0, rd, 7'h33};
  endfunction

  task automatic drive(input bit p, input logic v, input logic [31:0] instr, input logic we, input logic [31:0] wd);
    if (!p) begin a_valid = v; a_instr = instr; a_we = we; a_wdata = wd; end
    else    begin b_valid = v; b_instr = instr; b_we = we; b_wdata = wd; end
  endtask

  task automatic run_req(input bit p, input logic [31:0] instr, input logic we,
                         input logic [31:0] wd, input int hold);
    logic [31:0] e1, e2;
    int n;
    logic rdy, wr;
    @(negedge clk);
    drive(p, 1'b1, instr, we, wd);
    #1;
    n = 0;
    rdy = p ? b_ready : a_ready;
    while (!rdy && n < 8) begin
      @(negedge clk); #1; n++;
      rdy = p ? b_ready : a_ready;
    end
    chk("grant", {31'h0, rdy}, 32'h1);
    if (!rdy) begin drive(p, 1'b0, instr, we, wd); return; end
    @(posedge clk); #1;
    drive(p, 1'b0, instr, we, wd);
    wr = we && instr[11:7] != 5'd0;
    chk("issue_regwrite", {31'h0, rf_regwrite}, {31'h0, wr});
    chk("issue_instr", rf_instr, instr);
    chk("issue_wdata", rf_writedata, wd);
    chk("issue_busy", {31'h0, busy}, 32'h1);
    @(posedge clk); #1;
    chk("read_regwrite", {31'h0, rf_regwrite}, 32'h0);
    @(posedge clk); #1;
    e1 = ref_regs[instr[19:15]];
    e2 = ref_regs[instr[24:20]];
    chk("resp_valid_own", {31'h0, p ? b_resp_valid : a_resp_valid}, 32'h1);
    chk("resp_valid_other", {31'h0, p ? a_resp_valid : b_resp_valid}, 32'h0);
    chk("resp_rd1", resp_rd1, e1);
    chk("resp_rd2", resp_rd2, e2);
    if (wr) begin ref_regs[instr[11:7]] = wd; exp_writes++; end
    if (hold > 0) begin
      drive(!p, 1'b1, mk(5'd1, 5'd2, 5'd3), 1'b0, 32'h0);
      if (p) a_resp_ready = 1'b1; else b_resp_ready = 1'b1;
      for (int k = 0; k < hold; k++) begin
        @(posedge clk); #1;
        chk("hold_valid", {31'h0, p ? b_resp_valid : a_resp_valid}, 32'h1);
        chk("hold_other_ready", {31'h0, p ? a_ready : b_ready}, 32'h0);
      end
      chk("hold_rd1", resp_rd1, e1);
      chk("hold_rd2", resp_rd2, e2);
      drive(!p, 1'b0, 32'h0, 1'b0, 32'h0);
      a_resp_ready = 1'b0; b_resp_ready = 1'b0;
    end
    if (p) b_resp_ready = 1'b1; else a_resp_ready = 1'b1;
    @(posedge clk); #1;
    a_resp_ready = 1'b0; b_resp_ready = 1'b0;
    chk("done_busy", {31'h0, busy}, 32'h0);
    chk("done_valid", {30'h0, a_resp_valid, b_resp_valid}, 32'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_regwrite", {31'h0, rf_regwrite}, 32'h0);
    chk("rst_instr", rf_instr, 32'h0);
    chk("rst_resp", {30'h0, a_resp_valid, b_resp_valid}, 32'h0);
    chk("rst_rd1", resp_rd1, 32'h0);
    @(negedge clk);
    rst = 1'b0; clr = 1'b0;

    // Continuous tie: round-robin alternates from A, fixed priority always A
    a_valid = 1; b_valid = 1; a_resp_ready = 1; b_resp_ready = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("tie_rr", {30'h0, a_ready, b_ready}, (k % 2 == 0) ? 32'h2 : 32'h1);
      chk("tie_fp", {30'h0, fp_a_ready, fp_b_ready}, 32'h2);
      repeat (3) @(posedge clk);
      #1;
      chk("tie_lat", {30'h0, a_resp_valid, b_resp_valid}, (k % 2 == 0) ? 32'h2 : 32'h1);
      chk("tie_busy_rdy", {30'h0, a_ready, b_ready}, 32'h0);
      @(posedge clk);
      @(negedge clk);
    end
    a_valid = 0; b_valid = 0; a_resp_ready = 0; b_resp_ready = 0;
    repeat (6) @(posedge clk);

    run_req(0, mk(5'd0, 5'd0, 5'd5), 1'b1, 32'hDEADBEEF, 0);
    run_req(1, mk(5'd5, 5'd0, 5'd0), 1'b0, 32'h0, 0);
    run_req(0, mk(5'd0, 5'd0, 5'd7), 1'b1, 32'h11, 0);
    run_req(0, mk(5'd7, 5'd7, 5'd7), 1'b1, 32'h22, 0);
    run_req(1, mk(5'd7, 5'd5, 5'd0), 1'b0, 32'h0, 0);
    run_req(0, mk(5'd0, 5'd0, 5'd0), 1'b1, 32'hFFFFFFFF, 0);
    run_req(1, mk(5'd0, 5'd0, 5'd0), 1'b0, 32'h0, 0);
    run_req(1, mk(5'd5, 5'd7, 5'd9), 1'b0, 32'h0, 10);

    // Reset while a write sits in ISSUE
    @(negedge clk);
    drive(0, 1'b1, mk(5'd0, 5'd0, 5'd9), 1'b1, 32'hCAFE0009);
    @(posedge clk); #1;
    chk("rst_issue_regwrite", {31'h0, rf_regwrite}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_ready", {30'h0, a_ready, b_ready}, 32'h0);
    @(posedge clk); #1;
    ref_regs[9] = 32'hCAFE0009;
    exp_writes++;
    chk("rst_mid_regwrite", {31'h0, rf_regwrite}, 32'h0);
    chk("rst_mid_busy", {31'h0, busy}, 32'h0);
    chk("rst_mid_instr", rf_instr, 32'h0);
    drive(0, 1'b0, 32'h0, 1'b0, 32'h0);
    a_resp_ready = 1; b_resp_ready = 1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("rst_no_resp", {29'h0, a_resp_valid, b_resp_valid, busy}, 32'h0);
    end
    a_resp_ready = 0; b_resp_ready = 0;
    @(negedge clk);
    a_valid = 1; b_valid = 1;
    #1;
    chk("rst_tie_to_a", {30'h0, a_ready, b_ready}, 32'h2);
    a_valid = 0; b_valid = 0;
    run_req(1, mk(5'd9, 5'd5, 5'd0), 1'b0, 32'h0, 0);

    repeat (40) begin
      run_req(1'($urandom_range(0, 1)),
              mk(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))),
              1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3));
    end

    @(negedge clk);
    chk("wr_pulses", pulses, exp_writes);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
